hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// - Produces the operand-forwarding selects (forward_t) and the stall/flush controls for the 5-stage pipeline.
// - Drives the select inputs of the two execute-stage operand muxes.
// - Detects load-use hazards and data-bus wait states.
// - Holds a one-entry shadow of a retired writeback value so a frozen E stage can still forward it.
// PARAMETERS
// - REG_ADDR_W  5   register-index width; index 0 is x0 and is never forwarded
// - CNT_W       32  width of the statistic counters (used only with HAZARD_STATS_EN)
// PORTS
// - clk          in   1           pipeline clock
// - reset        in   1           synchronous, active-high reset
// - d_rs1, d_rs2 in   REG_ADDR_W  source registers of the D-stage instruction
// - e_rs1, e_rs2 in   REG_ADDR_W  source registers of the E-stage instruction
// - e_rd         in   REG_ADDR_W  destination of the E-stage instruction
// - e_memread    in   1           E-stage instruction is a load
// - m_rd         in   REG_ADDR_W  destination of the M-stage instruction
// - m_regwrite   in   1           M-stage instruction writes a register
// - m_memread    in   1           M-stage instruction is a load (result not yet available)
// - m_link       in   1           M-stage instruction is jal/jalr; its write value is pc+4
// - w_rd         in   REG_ADDR_W  destination of the W-stage instruction
// - w_regwrite   in   1           W-stage instruction writes a register
// - w_wd         in   word_t      W-stage write-back data
// - dreq_valid   in   1           M stage has an outstanding data-bus request
// - dresp_ok     in   1           data-bus response accepted this cycle
// - fwd_a, fwd_b out  forward_t   operand selects for the E-stage operand muxes
// - s_wd         out  word_t      shadow data; the Sregwd source
// - stall_fd     out  1           hold the F and D registers
// - stall_e      out  1           hold the E register
// - stall_m      out  1           hold the M register
// - flush_e      out  1           inject a bubble into E
// - flush_w      out  1           inject a bubble into W
// BEHAVIOUR
// - State machine, states RUN / LU_STALL / MEM_WAIT.
//   - RUN -> LU_STALL when e_memread & e_rd!=0 & (e_rd==d_rs1 | e_rd==d_rs2).
//   - LU_STALL lasts exactly 1 cycle, then RUN.
//   - Any state -> MEM_WAIT when dreq_valid & ~dresp_ok.
//   - MEM_WAIT -> RUN in the cycle after dresp_ok.
//   - MEM_WAIT has priority over LU_STALL; the load-use check is re-evaluated on return to RUN.
// - Outputs per state (all combinational from state and inputs):
//   - LU_STALL: stall_fd=1, flush_e=1.
//   - MEM_WAIT, and the dreq_valid & ~dresp_ok cycle itself: stall_fd = stall_e = stall_m = 1, flush_w=1.
//   - RUN: all stall/flush outputs 0.
// - fwd_a selection uses e_rs1; fwd_b is identical using e_rs2. The first matching rule wins:
//   1. rs==0 -> Rd (the default register-file value).
//   2. m_regwrite & m_rd==rs & m_link -> PCplus4.
//   3. m_regwrite & m_rd==rs & ~m_memread -> Result.
//   4. w_regwrite & w_rd==rs -> Wd.
//   5. shadow valid & shadow rd==rs -> Sregwd.
//   6. Otherwise -> Rd.
// - M-load match: an M-load matching rs cannot occur in RUN, because load-use is caught one stage earlier. If it does occur, select Rd.
// - Shadow register (valid, rd, data):
//   - Capture: on the rising edge where stall_e=1, flush_w=1 and w_regwrite & w_rd!=0 & w_rd is in {e_rs1, e_rs2}. Load valid=1, rd=w_rd, data=w_wd.
//   - Overwrite: a later capture overwrites the shadow, since the newest value wins.
//   - Clear: valid clears on the first edge where stall_e=0.
//   - Capture and clear in the same cycle: clear wins.
// - Reset (synchronous): state=RUN; shadow valid=0, rd=0, data=0; s_wd=0.
//   - With all inputs 0 after reset: fwd_a = fwd_b = Rd and all stalls/flushes = 0.
//   - Reset asserted mid MEM_WAIT or mid LU_STALL returns to RUN on that edge. The pipeline flush is the top level's job.
// - Latency: forward selects and stalls are combinational, with zero cycles of latency.
// CONFIGURATION
// - HAZARD_STATS_EN defined: adds outputs lu_stall_cnt, mem_stall_cnt and fwd_cnt, each CNT_W bits.
//   - lu_stall_cnt increments once per LU_STALL cycle.
//   - mem_stall_cnt increments once per MEM_WAIT cycle.
//   - fwd_cnt increments once per operand whose select is not Rd.
//   - All three saturate at all-ones and reset to 0.
// - HAZARD_STATS_EN undefined: the ports and counters are absent; everything else is unchanged.
// STRUCTURE
// - pipes package:
//   - forward_t stays there (Result, Wd, PCplus4, Sregwd, Rd).
//   - Add hazard_state_t {RUN, LU_STALL, MEM_WAIT}.
//   - Add creg_addr_t [REG_ADDR_W-1:0].
// - One sub-module, fwd_select: pure combinational priority logic instantiated twice, once per operand.
// - The FSM, shadow register and counters live in hazard_ctrl.
// TESTING
// - Reset with all inputs 0 -> fwd_a = fwd_b = Rd; stall_fd = stall_e = stall_m = flush_e = flush_w = 0; s_wd=0.
// - e_memread=1, e_rd=5, d_rs2=5 -> one cycle of stall_fd=1 & flush_e=1, then 0. Same stimulus with e_rd=0 -> no stall.
// - m_regwrite=1, m_rd=3, e_rs1=3 -> fwd_a=Result. Add m_link=1 -> PCplus4. Also w_rd=3 with w_regwrite=1 -> M rule still wins.
// - dreq_valid=1 with dresp_ok low for 3 cycles; W writes x7 = 0x1234 during the first cycle; e_rs2=7:
//   - fwd_b = Wd, then Sregwd with s_wd=0x1234.
//   - Stalls released in the cycle after dresp_ok; shadow clears when E advances.
// - Reset asserted while in MEM_WAIT -> RUN, shadow invalid, all stalls 0 after that edge.
// - HAZARD_STATS_EN build: 1 load-use plus a 3-cycle memory wait -> lu_stall_cnt=1, mem_stall_cnt=3.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states, address/word
// types.
package hazard_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned WordW    = 32;

  typedef logic [WordW-1:0]    word_t;
  typedef logic [RegAddrW-1:0] creg_addr_t;

  typedef enum logic [2:0] {
    Result,
    Wd,
    PCplus4,
    Sregwd,
    Rd
  } forward_t;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bus: stage register indices, data-bus handshake, forwarding
// selects and stall/flush controls.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  creg_addr_t d_rs1, d_rs2;
  creg_addr_t e_rs1, e_rs2, e_rd;
  logic       e_memread;
  creg_addr_t m_rd;
  logic       m_regwrite, m_memread, m_link;
  creg_addr_t w_rd;
  logic       w_regwrite;
  word_t      w_wd;
  logic       dreq_valid, dresp_ok;

  forward_t   fwd_a, fwd_b;
  word_t      s_wd;
  logic       stall_fd, stall_e, stall_m, flush_e, flush_w;

  modport master (
    output d_rs1, d_rs2, e_rs1, e_rs2, e_rd, e_memread,
    output m_rd, m_regwrite, m_memread, m_link,
    output w_rd, w_regwrite, w_wd, dreq_valid, dresp_ok,
    input  fwd_a, fwd_b, s_wd, stall_fd, stall_e, stall_m, flush_e, flush_w
  );

  modport slave (
    input  d_rs1, d_rs2, e_rs1, e_rs2, e_rd, e_memread,
    input  m_rd, m_regwrite, m_memread, m_link,
    input  w_rd, w_regwrite, w_wd, dreq_valid, dresp_ok,
    output fwd_a, fwd_b, s_wd, stall_fd, stall_e, stall_m, flush_e, flush_w
  );

endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// Priority forwarding select for one E-stage operand; purely combinational.
module hazard_ctrl_fwd_select
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned AddrW = RegAddrW
) (
  input  logic [AddrW-1:0] rs_i,
  input  logic [AddrW-1:0] m_rd_i,
  input  logic             m_regwrite_i,
  input  logic             m_memread_i,
  input  logic             m_link_i,
  input  logic [AddrW-1:0] w_rd_i,
  input  logic             w_regwrite_i,
  input  logic             sh_valid_i,
  input  logic [AddrW-1:0] sh_rd_i,
  output forward_t         sel_o
);

  always_comb begin
    sel_o = Rd;
    if (rs_i == '0) begin
      sel_o = Rd;
    end else if (m_regwrite_i && (m_rd_i == rs_i)) begin
      // An M-stage load has no result yet; fall back to the register file, never to older data.
      if (m_link_i) begin
        sel_o = PCplus4;
      end else if (!m_memread_i) begin
        sel_o = Result;
      end else begin
        sel_o = Rd;
      end
    end else if (w_regwrite_i && (w_rd_i == rs_i)) begin
      sel_o = Wd;
    end else if (sh_valid_i && (sh_rd_i == rs_i)) begin
      sel_o = Sregwd;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use / memory-wait FSM, writeback shadow register and operand forwarding.
// Optional statistic counters are enabled with the HAZARD_STATS_EN macro.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrW
`ifdef HAZARD_STATS_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
`endif
);

  hazard_state_t          state_q, state_d;
  logic                   sh_valid_q, sh_valid_d;
  logic [REG_ADDR_W-1:0]  sh_rd_q, sh_rd_d;
  word_t                  sh_data_q, sh_data_d;

  logic                   mem_wait_req, lu_hazard, mem_hold, w_hits_e;
  forward_t               fwd_a_sel, fwd_b_sel;

  always_comb begin
    mem_wait_req = bus.dreq_valid & ~bus.dresp_ok;
    lu_hazard    = bus.e_memread & (bus.e_rd != '0) &
                   ((bus.e_rd == bus.d_rs1) | (bus.e_rd == bus.d_rs2));
    state_d      = state_q;
    if (mem_wait_req) begin
      state_d = MEM_WAIT;
    end else begin
      case (state_q)
        RUN:     state_d = lu_hazard ? LU_STALL : RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // A pending memory wait dominates and suppresses the load-use bubble.
  assign mem_hold     = mem_wait_req | (state_q == MEM_WAIT);
  assign bus.stall_fd = mem_hold | (state_q == LU_STALL);
  assign bus.stall_e  = mem_hold;
  assign bus.stall_m  = mem_hold;
  assign bus.flush_w  = mem_hold;
  assign bus.flush_e  = ~mem_hold & (state_q == LU_STALL);

  assign w_hits_e = bus.w_regwrite & (bus.w_rd != '0) &
                    ((bus.w_rd == bus.e_rs1) | (bus.w_rd == bus.e_rs2));

  always_comb begin
    sh_valid_d = sh_valid_q;
    sh_rd_d    = sh_rd_q;
    sh_data_d  = sh_data_q;
    if (!bus.stall_e) begin
      sh_valid_d = 1'b0;
    end else if (bus.flush_w && w_hits_e) begin
      sh_valid_d = 1'b1;
      sh_rd_d    = bus.w_rd;
      sh_data_d  = bus.w_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      sh_valid_q <= 1'b0;
      sh_rd_q    <= '0;
      sh_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sh_valid_q <= sh_valid_d;
      sh_rd_q    <= sh_rd_d;
      sh_data_q  <= sh_data_d;
    end
  end

  assign bus.s_wd = sh_data_q;

  hazard_ctrl_fwd_select #(
    .AddrW (REG_ADDR_W)
  ) u_fwd_a (
    .rs_i         (bus.e_rs1),
    .m_rd_i       (bus.m_rd),
    .m_regwrite_i (bus.m_regwrite),
    .m_memread_i  (bus.m_memread),
    .m_link_i     (bus.m_link),
    .w_rd_i       (bus.w_rd),
    .w_regwrite_i (bus.w_regwrite),
    .sh_valid_i   (sh_valid_q),
    .sh_rd_i      (sh_rd_q),
    .sel_o        (fwd_a_sel)
  );

  hazard_ctrl_fwd_select #(
    .AddrW (REG_ADDR_W)
  ) u_fwd_b (
    .rs_i         (bus.e_rs2),
    .m_rd_i       (bus.m_rd),
    .m_regwrite_i (bus.m_regwrite),
    .m_memread_i  (bus.m_memread),
    .m_link_i     (bus.m_link),
    .w_rd_i       (bus.w_rd),
    .w_regwrite_i (bus.w_regwrite),
    .sh_valid_i   (sh_valid_q),
    .sh_rd_i      (sh_rd_q),
    .sel_o        (fwd_b_sel)
  );

  assign bus.fwd_a = fwd_a_sel;
  assign bus.fwd_b = fwd_b_sel;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [1:0]       fwd_inc;
  logic [CNT_W:0]   fwd_sum;

  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if ((state_q == LU_STALL) && (lu_cnt_q != '1)) begin
      lu_cnt_d = lu_cnt_q + CNT_W'(1);
    end
    if ((state_q == MEM_WAIT) && (mem_cnt_q != '1)) begin
      mem_cnt_d = mem_cnt_q + CNT_W'(1);
    end
    fwd_inc   = {1'b0, fwd_a_sel != Rd} + {1'b0, fwd_b_sel != Rd};
    fwd_sum   = {1'b0, fwd_cnt_q} + {{(CNT_W - 1){1'b0}}, fwd_inc};
    fwd_cnt_d = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
      fwd_cnt_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

  assign lu_stall_cnt  = lu_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;
  assign fwd_cnt       = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (stat counters checked when HAZARD_STATS_EN is set).
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hbus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] lu_stall_cnt, mem_stall_cnt, fwd_cnt;
`endif

  hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (hbus)
`ifdef HAZARD_STATS_EN
    ,
    .lu_stall_cnt  (lu_stall_cnt),
    .mem_stall_cnt (mem_stall_cnt),
    .fwd_cnt       (fwd_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {stall_fd, stall_e, stall_m, flush_e, flush_w}
  function automatic logic [31:0] ctl();
    return {27'b0, hbus.stall_fd, hbus.stall_e, hbus.stall_m, hbus.flush_e, hbus.flush_w};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hbus.d_rs1 = '0; hbus.d_rs2 = '0;
    hbus.e_rs1 = '0; hbus.e_rs2 = '0; hbus.e_rd = '0; hbus.e_memread = 1'b0;
    hbus.m_rd = '0; hbus.m_regwrite = 1'b0; hbus.m_memread = 1'b0; hbus.m_link = 1'b0;
    hbus.w_rd = '0; hbus.w_regwrite = 1'b0; hbus.w_wd = '0;
    hbus.dreq_valid = 1'b0; hbus.dresp_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    #1;
    check_eq("rst_fwd_a", hbus.fwd_a, Rd);
    check_eq("rst_fwd_b", hbus.fwd_b, Rd);
    check_eq("rst_ctl", ctl(), 32'h0);
    check_eq("rst_s_wd", hbus.s_wd, 32'h0);
`ifdef HAZARD_STATS_EN
    check_eq("rst_fwd_cnt", fwd_cnt, 32'h0);
`endif

    // Load-use on rs2: one cycle of stall_fd + flush_e.
    hbus.e_memread = 1'b1; hbus.e_rd = 5'd5; hbus.d_rs2 = 5'd5;
    #1;
    check_eq("lu_detect_cycle", ctl(), 32'h0);
    step();
    clear_inputs();
    #1;
    check_eq("lu_stall", ctl(), 32'h12);
    step();
    check_eq("lu_release", ctl(), 32'h0);
    hbus.e_memread = 1'b1; hbus.e_rd = 5'd0; hbus.d_rs2 = 5'd0;
    step();
    check_eq("lu_x0_nostall", ctl(), 32'h0);
    clear_inputs();

    // Forwarding priority on operand A.
    hbus.m_regwrite = 1'b1; hbus.m_rd = 5'd3; hbus.e_rs1 = 5'd3;
    #1;
    check_eq("fwd_result", hbus.fwd_a, Result);
    check_eq("fwd_b_untouched", hbus.fwd_b, Rd);
    hbus.m_link = 1'b1;
    #1;
    check_eq("fwd_pcplus4", hbus.fwd_a, PCplus4);
    hbus.m_link = 1'b0; hbus.w_regwrite = 1'b1; hbus.w_rd = 5'd3;
    #1;
    check_eq("fwd_m_over_w", hbus.fwd_a, Result);
    hbus.m_memread = 1'b1;
    #1;
    check_eq("fwd_mload_rd", hbus.fwd_a, Rd);
    hbus.m_regwrite = 1'b0; hbus.m_memread = 1'b0;
    #1;
    check_eq("fwd_wd", hbus.fwd_a, Wd);
    hbus.e_rs1 = 5'd0; hbus.w_rd = 5'd0; hbus.m_regwrite = 1'b1; hbus.m_rd = 5'd0;
    #1;
    check_eq("fwd_x0", hbus.fwd_a, Rd);
    clear_inputs();
    step();

    // Memory wait with shadow capture of x7.
    hbus.dreq_valid = 1'b1; hbus.e_rs2 = 5'd7;
    hbus.w_regwrite = 1'b1; hbus.w_rd = 5'd7; hbus.w_wd = 32'h1234;
    #1;
    check_eq("mw_fwd_wd", hbus.fwd_b, Wd);
    check_eq("mw_ctl_req", ctl(), 32'h1d);
    step();
    hbus.w_regwrite = 1'b0; hbus.w_rd = '0; hbus.w_wd = '0;
    #1;
    check_eq("mw_fwd_shadow", hbus.fwd_b, Sregwd);
    check_eq("mw_s_wd", hbus.s_wd, 32'h1234);
    check_eq("mw_ctl_wait1", ctl(), 32'h1d);
    step();
    check_eq("mw_ctl_wait2", ctl(), 32'h1d);
    check_eq("mw_fwd_shadow2", hbus.fwd_b, Sregwd);
    step();
    hbus.dresp_ok = 1'b1;
    #1;
    check_eq("mw_ctl_resp", ctl(), 32'h1d);
    step();
    hbus.dreq_valid = 1'b0; hbus.dresp_ok = 1'b0;
    #1;
    check_eq("mw_released", ctl(), 32'h0);
    check_eq("mw_shadow_held", hbus.fwd_b, Sregwd);
    step();
    check_eq("mw_shadow_clear", hbus.fwd_b, Rd);
`ifdef HAZARD_STATS_EN
    check_eq("stat_lu", lu_stall_cnt, 32'd1);
    check_eq("stat_mem", mem_stall_cnt, 32'd3);
`endif
    clear_inputs();

    // Reset in the middle of a memory wait.
    hbus.dreq_valid = 1'b1; hbus.e_rs2 = 5'd7;
    hbus.w_regwrite = 1'b1; hbus.w_rd = 5'd7; hbus.w_wd = 32'hbeef;
    step();
    hbus.w_regwrite = 1'b0;
    #1;
    check_eq("rmw_in_wait", hbus.fwd_b, Sregwd);
    reset = 1'b1; hbus.dreq_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check_eq("rmw_ctl", ctl(), 32'h0);
    check_eq("rmw_fwd_b", hbus.fwd_b, Rd);
    check_eq("rmw_s_wd", hbus.s_wd, 32'h0);
    step();
    check_eq("rmw_stays_run", ctl(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
